interrupt_arbiter: RTL and testbench

// Upstream feeder of the global-control unit's interrupt path: synchronises raw interrupt lines,

---
 rtl/interrupt_arbiter.sv | 105 ++++++++++
 tb/tb_interrupt_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: synchronises raw interrupt lines, masks and prioritises them, and
// presents a registered pending/cause pair to the global-control unit with a post-take holdoff.
module interrupt_arbiter #(
  parameter int INCLUDE_S_MODE = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] irq_in,
  input  logic [11:0] mie,
  input  logic        mstatus_mie,
  input  logic        priv_is_m,
  input  logic        interrupt_taken,
  output logic        interrupt_pending,
  output logic [3:0]  interrupt_cause,
  output logic [11:0] mip
);

  localparam logic [11:0] M_MASK    = 12'h888;  // codes 11, 7, 3
  localparam logic [11:0] S_MASK    = 12'h222;  // codes 9, 5, 1
  localparam logic [11:0] SUPPORTED = M_MASK | ((INCLUDE_S_MODE != 0) ? S_MASK : 12'h000);
  localparam int          CW        = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [CW:0] HOLD_LIM  = (CW + 1)'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {IDLE, PENDING, HOLDOFF} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [CW:0]   cnt_inc;
  logic [11:0]   sync_q [SYNC_STAGES];
  logic [11:0]   enabled;
  logic          global_en;
  logic [3:0]    sel;
  logic          pending_d;
  logic [3:0]    cause_d;

  // Unsupported lines are masked at the first stage so their flops prune away;
  // the last stage is the architectural mip view.
  // NOTE: every synchroniser stage is reset so a mid-run reset cannot leak a stale edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_in & SUPPORTED;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign mip       = sync_q[SYNC_STAGES-1];
  assign enabled   = mip & mie;
  assign global_en = mstatus_mie | ~priv_is_m;
  assign cnt_inc   = {1'b0, cnt_q} + (CW + 1)'(1);

  // Fixed priority: MEI, MSI, MTI, SEI, SSI, STI.
  // NOTE: defaulting every always_comb output first keeps latches from being inferred.
  always_comb begin
    sel = 4'd0;
    if      (enabled[11]) sel = 4'd11;
    else if (enabled[3])  sel = 4'd3;
    else if (enabled[7])  sel = 4'd7;
    else if (enabled[9])  sel = 4'd9;
    else if (enabled[1])  sel = 4'd1;
    else if (enabled[5])  sel = 4'd5;
  end

  // State register, holdoff counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      interrupt_pending <= 1'b0;
      interrupt_cause   <= 4'd0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= (state_q == HOLDOFF && state_d == HOLDOFF) ? cnt_inc[CW-1:0] : '0;
      interrupt_pending <= pending_d;
      interrupt_cause   <= cause_d;
    end
  end

  // Next state: a take beats a simultaneous withdrawal; sources are ignored in holdoff.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((|enabled) && global_en) state_d = PENDING;
      PENDING: begin
        if (interrupt_taken)                  state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
        else if (!(|enabled) || !global_en)   state_d = IDLE;
      end
      HOLDOFF: if (cnt_inc == HOLD_LIM)       state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Cause tracks the live selection while pending and freezes otherwise.
  always_comb begin
    pending_d = (state_d == PENDING);
    cause_d   = pending_d ? sel : interrupt_cause;
  end

  taken_implies_pending: assert property (
    @(posedge clk) disable iff (rst) interrupt_taken |-> interrupt_pending);

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: hand-timed sequences for latency, take/holdoff and
// reset corners, followed by a table of steady-state masking and priority vectors.
module tb_interrupt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] irq_in;
  logic [11:0] mie;
  logic        mstatus_mie;
  logic        priv_is_m;
  logic        interrupt_taken;
  logic        interrupt_pending;
  logic [3:0]  interrupt_cause;
  logic [11:0] mip;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [11:0] irq;
    logic [11:0] mie;
    logic        mstatus_mie;
    logic        priv_is_m;
    logic        exp_pending;
    logic        chk_cause;
    logic [3:0]  exp_cause;
    logic [11:0] exp_mip;
  } vec_t;

  vec_t vecs [11];

  interrupt_arbiter #(
    .INCLUDE_S_MODE(0),
    .SYNC_STAGES   (2),
    .HOLDOFF_CYCLES(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .irq_in           (irq_in),
    .mie              (mie),
    .mstatus_mie      (mstatus_mie),
    .priv_is_m        (priv_is_m),
    .interrupt_taken  (interrupt_taken),
    .interrupt_pending(interrupt_pending),
    .interrupt_cause  (interrupt_cause),
    .mip              (mip)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic p, input logic [3:0] c, input logic [11:0] m);
    check({name, ".pending"}, 32'(interrupt_pending), 32'(p));
    check({name, ".cause"},   32'(interrupt_cause),   32'(c));
    check({name, ".mip"},     32'(mip),               32'(m));
  endtask

  initial begin
    vecs[0]  = '{12'h080, 12'h080, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  12'h080};
    vecs[1]  = '{12'h880, 12'h880, 1'b1, 1'b1, 1'b1, 1'b1, 4'd11, 12'h880};
    vecs[2]  = '{12'h088, 12'h088, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  12'h088};
    vecs[3]  = '{12'h088, 12'h080, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  12'h088};
    vecs[4]  = '{12'h200, 12'h200, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  12'h000};
    vecs[5]  = '{12'h2AA, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  12'h088};
    vecs[6]  = '{12'h800, 12'h800, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  12'h800};
    vecs[7]  = '{12'h800, 12'h800, 1'b0, 1'b0, 1'b1, 1'b1, 4'd11, 12'h800};
    vecs[8]  = '{12'h800, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  12'h800};
    vecs[9]  = '{12'h004, 12'hFFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  12'h000};
    vecs[10] = '{12'h888, 12'h088, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  12'h888};

    rst = 1'b1; irq_in = '0; mie = '0; mstatus_mie = 1'b0; priv_is_m = 1'b1; interrupt_taken = 1'b0;
    repeat (3) step();
    check_outs("reset", 1'b0, 4'd0, 12'h000);
    rst = 1'b0;

    // Latency: mip two cycles after the line rises, pending one cycle later.
    irq_in = 12'h080; mie = 12'h080; mstatus_mie = 1'b1; priv_is_m = 1'b1;
    step(); check("lat1.mip", 32'(mip), 32'h000);
    step(); check("lat2.mip", 32'(mip), 32'h080); check("lat2.pending", 32'(interrupt_pending), 0);
    step(); check("lat3.pending", 32'(interrupt_pending), 1); check("lat3.cause", 32'(interrupt_cause), 7);

    // Higher-priority arrival replaces the cause without dropping pending.
    irq_in = 12'h880; mie = 12'h880;
    step(); check("pre1.cause", 32'(interrupt_cause), 7); check("pre1.pending", 32'(interrupt_pending), 1);
    step(); check("pre2.mip", 32'(mip), 32'h880);   check("pre2.cause", 32'(interrupt_cause), 7);
    step(); check("pre3.cause", 32'(interrupt_cause), 11); check("pre3.pending", 32'(interrupt_pending), 1);

    // Take: pending low for three cycles, then re-asserts with the remaining line.
    irq_in = 12'h080;
    repeat (3) step();
    check("drop11.cause", 32'(interrupt_cause), 7);
    interrupt_taken = 1'b1;
    step(); check("hold0.pending", 32'(interrupt_pending), 0);
    interrupt_taken = 1'b0;
    step(); check("hold1.pending", 32'(interrupt_pending), 0);
    step(); check("hold2.pending", 32'(interrupt_pending), 0);
    step(); check("hold3.pending", 32'(interrupt_pending), 1); check("hold3.cause", 32'(interrupt_cause), 7);

    // Take and withdrawal together: the take wins, so holdoff still applies.
    interrupt_taken = 1'b1; mstatus_mie = 1'b0;
    step(); check("tw0.pending", 32'(interrupt_pending), 0);
    interrupt_taken = 1'b0; mstatus_mie = 1'b1;
    step(); check("tw1.pending", 32'(interrupt_pending), 0);
    step(); check("tw2.pending", 32'(interrupt_pending), 0);
    step(); check("tw3.pending", 32'(interrupt_pending), 1);

    // Global enable withdrawal, then lower privilege re-permits.
    mstatus_mie = 1'b0;
    step(); check("gen0.pending", 32'(interrupt_pending), 0);
    step(); check("gen1.pending", 32'(interrupt_pending), 0);
    priv_is_m = 1'b0;
    step(); check("gen2.pending", 32'(interrupt_pending), 1); check("gen2.cause", 32'(interrupt_cause), 7);
    priv_is_m = 1'b1; mstatus_mie = 1'b1;
    step(); check("gen3.pending", 32'(interrupt_pending), 1);

    // Reset while pending, then re-pend after SYNC_STAGES+1 cycles.
    rst = 1'b1;
    step(); check_outs("rstp", 1'b0, 4'd0, 12'h000);
    rst = 1'b0;
    step(); check("rstp1.pending", 32'(interrupt_pending), 0);
    step(); check("rstp2.pending", 32'(interrupt_pending), 0);
    step(); check("rstp3.pending", 32'(interrupt_pending), 1); check("rstp3.cause", 32'(interrupt_cause), 7);

    // Reset during holdoff.
    interrupt_taken = 1'b1;
    step();
    interrupt_taken = 1'b0;
    step(); check("rsth0.pending", 32'(interrupt_pending), 0);
    rst = 1'b1;
    step(); check_outs("rsth", 1'b0, 4'd0, 12'h000);
    rst = 1'b0;
    step(); check("rsth1.pending", 32'(interrupt_pending), 0);
    step(); check("rsth2.pending", 32'(interrupt_pending), 0);
    step(); check("rsth3.pending", 32'(interrupt_pending), 1);

    // Steady-state masking and priority table.
    for (int i = 0; i < 11; i++) begin
      irq_in = vecs[i].irq; mie = vecs[i].mie;
      mstatus_mie = vecs[i].mstatus_mie; priv_is_m = vecs[i].priv_is_m;
      repeat (6) step();
      check($sformatf("vec%0d.pending", i), 32'(interrupt_pending), 32'(vecs[i].exp_pending));
      check($sformatf("vec%0d.mip", i), 32'(mip), 32'(vecs[i].exp_mip));
      if (vecs[i].chk_cause)
        check($sformatf("vec%0d.cause", i), 32'(interrupt_cause), 32'(vecs[i].exp_cause));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
